// File: rtl/cam_scan_pkg.sv
// ============================================================================
// Module   : cam_scan_pkg
// Brief    : Shared types and constants for the CAM hit-vector scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_scan_pkg;

    localparam int CAM_WIDTH_DEFAULT = 64;
    localparam int CAM_CHUNK_DEFAULT = 4;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cam_chunk_prio.sv
// ============================================================================
// Module   : cam_chunk_prio
// Brief    : Combinational CHUNK-bit priority encoder; picks the lowest set
//            bit for ascending scans and the highest for descending scans.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_chunk_prio
    import cam_scan_pkg::*;
#(
    parameter int CHUNK = CAM_CHUNK_DEFAULT,
    parameter int OFFW  = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic             dir,
    output logic             any,
    output logic [OFFW-1:0]  offset
);

    always_comb begin
        any    = |chunk;
        offset = '0;
        if (dir == DIR_ASC) begin
            // Walk downwards so the last write is the lowest set bit.
            for (int i = CHUNK - 1; i >= 0; i--) begin
                if (chunk[i]) offset = OFFW'(i);
            end
        end else begin
            for (int i = 0; i < CHUNK; i++) begin
                if (chunk[i]) offset = OFFW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cam_hit_scanner.sv
// ============================================================================
// Module   : cam_hit_scanner
// Brief    : Iterative CAM hit-vector scanner; streams the index of every set
//            bit CHUNK lanes per cycle and reports the hit count at the end.
//            Optional hit limit / truncation flag: CAM_HIT_SCAN_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_hit_scanner
    import cam_scan_pkg::*;
#(
    parameter int WIDTH = CAM_WIDTH_DEFAULT,
    parameter int CHUNK = CAM_CHUNK_DEFAULT,
    parameter int IDXW  = $clog2(WIDTH),
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_dir,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDXW-1:0]  idx,
    output logic             done_valid,
    output logic [CNTW-1:0]  done_count,
`ifdef CAM_HIT_SCAN_LIMIT_EN
    input  logic [CNTW-1:0]  hit_limit,
    output logic             done_trunc,
`endif
    output logic             busy
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OFFW = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(NCH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  vec_q,   vec_d;
    logic [PW-1:0]     ptr_q,   ptr_d;
    logic              dir_q,   dir_d;
    logic [CNTW-1:0]   cnt_q,   cnt_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
`ifdef CAM_HIT_SCAN_LIMIT_EN
    logic [CNTW-1:0]   limit_q, limit_d;
    logic              trunc_q, trunc_d;
`endif

    logic [CHUNK-1:0]  w_chunk;
    logic              w_any;
    logic [OFFW-1:0]   w_off;
    logic [IDXW-1:0]   w_hit_idx;
    logic              w_last;

    assign w_chunk   = vec_q[int'(ptr_q) * CHUNK +: CHUNK];
    assign w_hit_idx = IDXW'(int'(ptr_q) * CHUNK + int'(w_off));
    assign w_last    = (dir_q == DIR_ASC) ? (ptr_q == PTR_LAST) : (ptr_q == '0);

    cam_chunk_prio #(
        .CHUNK (CHUNK),
        .OFFW  (OFFW)
    ) u_prio (
        .chunk  (w_chunk),
        .dir    (dir_q),
        .any    (w_any),
        .offset (w_off)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ptr_d   = ptr_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef CAM_HIT_SCAN_LIMIT_EN
        limit_d = limit_q;
        trunc_d = trunc_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d   = in_vec;
                    dir_d   = in_dir;
                    ptr_d   = (in_dir == DIR_DESC) ? PTR_LAST : '0;
                    cnt_d   = '0;
`ifdef CAM_HIT_SCAN_LIMIT_EN
                    limit_d = hit_limit;
                    trunc_d = 1'b0;
`endif
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (w_any) begin
                    idx_d            = w_hit_idx;
                    vec_d[w_hit_idx] = 1'b0;
                    cnt_d            = cnt_q + CNTW'(1);
                    state_d          = EMIT;
                end else if (w_last) begin
                    state_d = DONE;
                end else if (dir_q == DIR_ASC) begin
                    ptr_d = ptr_q + PW'(1);
                end else begin
                    ptr_d = ptr_q - PW'(1);
                end
            end
            EMIT: begin
                if (idx_ready) begin
                    state_d = SCAN;
`ifdef CAM_HIT_SCAN_LIMIT_EN
                    // cnt_q already includes the hit just handed off.
                    if ((limit_q != '0) && (cnt_q == limit_q)) begin
                        trunc_d = |vec_q;
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q <= IDLE;
            vec_q   <= '0;
            ptr_q   <= '0;
            dir_q   <= DIR_ASC;
            cnt_q   <= '0;
            idx_q   <= '0;
`ifdef CAM_HIT_SCAN_LIMIT_EN
            limit_q <= '0;
            trunc_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
`ifdef CAM_HIT_SCAN_LIMIT_EN
            limit_q <= limit_d;
            trunc_q <= trunc_d;
`endif
        end
    end

    assign in_ready   = reset_l && (state_q == IDLE);
    assign idx_valid  = (state_q == EMIT);
    assign idx        = idx_q;
    assign done_valid = (state_q == DONE);
    assign done_count = cnt_q;
    assign busy       = (state_q != IDLE);
`ifdef CAM_HIT_SCAN_LIMIT_EN
    assign done_trunc = trunc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cam_hit_scanner.sv
// ============================================================================
// Module   : tb_cam_hit_scanner
// Brief    : Directed self-checking bench for cam_hit_scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_hit_scanner;

    localparam int WIDTH = 64;
    localparam int CHUNK = 4;
    localparam int IDXW  = 6;
    localparam int CNTW  = 7;

    logic             clk = 1'b0;
    logic             reset_l;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             in_dir;
    logic             idx_valid;
    logic             idx_ready;
    logic [IDXW-1:0]  idx;
    logic             done_valid;
    logic [CNTW-1:0]  done_count;
    logic             busy;
`ifdef CAM_HIT_SCAN_LIMIT_EN
    logic [CNTW-1:0]  hit_limit;
    logic             done_trunc;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int last_done_cyc;

    always #5 clk = ~clk;

    cam_hit_scanner #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .IDXW  (IDXW),
        .CNTW  (CNTW)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .in_dir     (in_dir),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx        (idx),
        .done_valid (done_valid),
        .done_count (done_count),
`ifdef CAM_HIT_SCAN_LIMIT_EN
        .hit_limit  (hit_limit),
        .done_trunc (done_trunc),
`endif
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offers one vector, then drives idx_ready (stalling 'stall' cycles per
    // hit) and compares the emitted stream against exp_q.
    task automatic run_scan(input string name, input logic [63:0] vec, input logic dir,
                            input int stall, input int limit, input bit noise,
                            input int exp_cnt, input logic exp_trunc);
        int  k = 0;
        int  stall_cnt = 0;
        bit  got_done = 0;
        bit  hold_bad = 0;
        bit  ready_bad = 0;
        bit  extra = 0;
        logic [IDXW-1:0] held = '0;
        @(negedge clk);
        check({name, "_in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        in_vec    = vec;
        in_dir    = dir;
        idx_ready = 1'b0;
`ifdef CAM_HIT_SCAN_LIMIT_EN
        hit_limit = CNTW'(limit);
`else
        if (limit != 0) $display("[TB] note: limit %0d ignored without limit feature", limit);
`endif
        @(negedge clk);
        in_valid = noise;
        in_vec   = ~vec;
        in_dir   = ~dir;
        for (int cyc = 1; cyc < 5000 && !got_done; cyc++) begin
            if (in_ready || !busy) ready_bad = 1;
            if (idx_valid) begin
                if (stall_cnt > 0) begin
                    if (idx !== held) hold_bad = 1;
                end else begin
                    held = idx;
                end
                if (stall_cnt < stall) begin
                    idx_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    idx_ready = 1'b1;
                    if (k < exp_q.size())
                        check($sformatf("%s_idx%0d", name, k), idx, exp_q[k]);
                    else
                        extra = 1;
                    k++;
                    stall_cnt = 0;
                end
            end else begin
                idx_ready = 1'b0;
            end
            if (done_valid) begin
                got_done      = 1;
                last_done_cyc = cyc;
                in_valid      = 1'b0;
                check({name, "_done_count"}, done_count, exp_cnt);
`ifdef CAM_HIT_SCAN_LIMIT_EN
                check({name, "_done_trunc"}, done_trunc, exp_trunc);
`else
                if (exp_trunc) $display("[TB] note: trunc flag not present in this build");
`endif
            end else begin
                @(negedge clk);
            end
        end
        idx_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, "_done_seen"}, got_done, 1);
        check({name, "_n_idx"}, k, exp_q.size());
        check({name, "_no_extra"}, extra, 0);
        check({name, "_idx_hold"}, hold_bad, 0);
        check({name, "_busy_not_ready"}, ready_bad, 0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, done_valid, 0);
        check({name, "_back_idle"}, in_ready, 1);
    endtask

    initial begin
        bit seen;
        bit leak;
        reset_l   = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        in_dir    = 1'b0;
        idx_ready = 1'b0;
`ifdef CAM_HIT_SCAN_LIMIT_EN
        hit_limit = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_idx_valid", idx_valid, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", idx, 0);
        check("rst_done_count", done_count, 0);
        reset_l = 1'b1;

        exp_q = '{16, 48};
        run_scan("asc2", 64'h00010000_00010000, 1'b0, 0, 0, 1'b1, 2, 1'b0);
        exp_q = '{48, 16};
        run_scan("desc2", 64'h00010000_00010000, 1'b1, 0, 0, 1'b0, 2, 1'b0);
        exp_q = '{0, 16, 36, 48, 56};
        run_scan("asc5", 64'h01010010_00010001, 1'b0, 0, 0, 1'b0, 5, 1'b0);
        exp_q = '{56, 48, 36, 16, 0};
        run_scan("desc5", 64'h01010010_00010001, 1'b1, 1, 0, 1'b0, 5, 1'b0);
        exp_q = {};
        run_scan("zero", 64'h0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        check("zero_done_latency", last_done_cyc, 17);
        exp_q = {};
        for (int i = 0; i < 64; i++) exp_q.push_back(i);
        run_scan("ones", {64{1'b1}}, 1'b0, 3, 0, 1'b1, 64, 1'b0);
        exp_q = {};
        exp_q.push_back(63);
        exp_q.push_back(0);
        run_scan("desc_edges", 64'h80000000_00000001, 1'b1, 0, 0, 1'b0, 2, 1'b0);

        // Abort during EMIT of idx 16.
        @(negedge clk);
        in_valid  = 1'b1;
        in_vec    = 64'h00010000_00010000;
        in_dir    = 1'b0;
        idx_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (idx_valid) seen = 1;
            else @(negedge clk);
        end
        check("abort_emit_seen", seen, 1);
        check("abort_first_idx", idx, 16);
        reset_l = 1'b0;
        @(negedge clk);
        check("abort_in_ready_low", in_ready, 0);
        check("abort_busy", busy, 0);
        reset_l   = 1'b1;
        idx_ready = 1'b1;
        leak = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (idx_valid || done_valid) leak = 1;
        end
        check("abort_no_output", leak, 0);
        exp_q = '{0};
        run_scan("after_abort", 64'h1, 1'b0, 0, 0, 1'b0, 1, 1'b0);

`ifdef CAM_HIT_SCAN_LIMIT_EN
        exp_q = '{0, 16};
        run_scan("limit2", 64'h01010010_00010001, 1'b0, 0, 2, 1'b0, 2, 1'b1);
        exp_q = '{0, 16, 36, 48, 56};
        run_scan("limit5", 64'h01010010_00010001, 1'b0, 0, 5, 1'b0, 5, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
